// File: rtl/layer_inter_pingpong_ctrl.sv
// Multi-bank ping-pong sequencer that routes producer/consumer layer RAM ports onto their owned bank.
// Latency: run control and ownership are registered; bank routing is combinational from them.
// Backpressure: the producer waits while every bank is full and the consumer waits while none is.
module layer_inter_pingpong_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_BANKS  = 2,
    parameter int SEL_WIDTH  = 2,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            former_done,
    input  logic                            next_done,
    output logic                            former_enable,
    output logic                            former_reset,
    output logic                            next_enable,
    output logic                            next_reset,
    input  logic [ADDR_WIDTH-1:0]           former_addr_a,
    input  logic [ADDR_WIDTH-1:0]           former_addr_b,
    input  logic [3:0]                      former_ctl,
    input  logic [ADDR_WIDTH-1:0]           next_addr_a,
    input  logic [ADDR_WIDTH-1:0]           next_addr_b,
    input  logic [3:0]                      next_ctl,
    output logic [NUM_BANKS*ADDR_WIDTH-1:0] bank_addr_a,
    output logic [NUM_BANKS*ADDR_WIDTH-1:0] bank_addr_b,
    output logic [NUM_BANKS*4-1:0]          bank_ctl,
    output logic [SEL_WIDTH-1:0]            rd_bank_sel,
    output logic [CNT_WIDTH-1:0]            full_cnt,
    output logic [15:0]                     frames_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } run_state_t;

    localparam logic [CNT_WIDTH-1:0] ALL_FULL  = CNT_WIDTH'(NUM_BANKS);
    localparam logic [SEL_WIDTH-1:0] LAST_BANK = SEL_WIDTH'(NUM_BANKS - 1);

    run_state_t           prod_state;
    run_state_t           prod_next;
    run_state_t           cons_state;
    run_state_t           cons_next;
    logic [SEL_WIDTH-1:0] wr_bank;
    logic [SEL_WIDTH-1:0] rd_bank;
    logic                 prod_fin;
    logic                 cons_fin;
    logic                 cons_launch;

    // Done pulses only count while the matching layer is actually running.
    assign prod_fin    = (prod_state == RUN) && former_done;
    assign cons_fin    = (cons_state == RUN) && next_done;
    assign cons_launch = (cons_state == IDLE) && (full_cnt != '0);

    assign former_reset  = (prod_state == START);
    assign former_enable = (prod_state == RUN);
    assign next_reset    = (cons_state == START);
    assign next_enable   = (cons_state == RUN);

    // Producer next state: launch only while enabled and a bank is free.
    always_comb begin
        prod_next = prod_state;
        case (prod_state)
            IDLE:    if (enable && (full_cnt < ALL_FULL)) prod_next = START;
            START:   prod_next = RUN;
            RUN:     if (former_done) prod_next = IDLE;
            default: prod_next = IDLE;
        endcase
    end

    // Consumer next state: drains any filled bank regardless of enable.
    always_comb begin
        cons_next = cons_state;
        case (cons_state)
            IDLE:    if (full_cnt != '0) cons_next = START;
            START:   cons_next = RUN;
            RUN:     if (next_done) cons_next = IDLE;
            default: cons_next = IDLE;
        endcase
    end

    // State, bank pointers, occupancy and frame counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            prod_state  <= IDLE;
            cons_state  <= IDLE;
            wr_bank     <= '0;
            rd_bank     <= '0;
            rd_bank_sel <= '0;
            full_cnt    <= '0;
            frames_done <= '0;
        end else begin
            prod_state <= prod_next;
            cons_state <= cons_next;
            if (prod_fin) begin
                wr_bank <= (wr_bank == LAST_BANK) ? '0 : wr_bank + SEL_WIDTH'(1);
            end
            if (cons_fin) begin
                rd_bank     <= (rd_bank == LAST_BANK) ? '0 : rd_bank + SEL_WIDTH'(1);
                frames_done <= frames_done + 16'd1;
            end
            // Read mux select is latched at consumer launch so it holds over the
            // cycle after next_done, when the last read data is still returning.
            if (cons_launch) begin
                rd_bank_sel <= rd_bank;
            end
            case ({prod_fin, cons_fin})
                2'b10:   full_cnt <= full_cnt + CNT_WIDTH'(1);
                2'b01:   full_cnt <= full_cnt - CNT_WIDTH'(1);
                default: full_cnt <= full_cnt;
            endcase
        end
    end

    // Route each layer's ports onto its owned bank; idle or unowned banks see zeros.
    always_comb begin
        bank_addr_a = '0;
        bank_addr_b = '0;
        bank_ctl    = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if ((prod_state == RUN) && (wr_bank == SEL_WIDTH'(i))) begin
                bank_addr_a[i*ADDR_WIDTH +: ADDR_WIDTH] = former_addr_a;
                bank_addr_b[i*ADDR_WIDTH +: ADDR_WIDTH] = former_addr_b;
                bank_ctl[i*4 +: 4]                      = former_ctl;
            end else if ((cons_state == RUN) && (rd_bank == SEL_WIDTH'(i))) begin
                bank_addr_a[i*ADDR_WIDTH +: ADDR_WIDTH] = next_addr_a;
                bank_addr_b[i*ADDR_WIDTH +: ADDR_WIDTH] = next_addr_b;
                bank_ctl[i*4 +: 4]                      = next_ctl;
            end
        end
    end

    // Occupancy rules must keep both layers off the same bank at once.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!((prod_state == RUN) && (cons_state == RUN) && (wr_bank == rd_bank)));
        end
    end

endmodule
